// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//  - Default widths for register numbers and forwarding selects.
//  - Forwarding-select encodings for the E-stage operand muxes.
//  - Control FSM state type.
//  - Shadow pipeline slot struct and the empty slot value.
//  - producer_match(): "this slot writes a non-zero register equal to src".
package pipe_ctrl_pkg;

  localparam int REG_AW_P = 5;
  localparam int FWD_W_P  = 2;

  // Operand source encodings (names kept distinct from the FWD_W width parameter)
  localparam logic [FWD_W_P-1:0] FWD_SRC_RF = 2'b00;
  localparam logic [FWD_W_P-1:0] FWD_SRC_M  = 2'b01;
  localparam logic [FWD_W_P-1:0] FWD_SRC_W  = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic                valid;
    logic [REG_AW_P-1:0] rd;
    logic                reg_we;
    logic                is_load;
    logic                is_mem;
    logic                is_halt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{default: 1'b0};

  // x0 is hard-wired, so a write to it is never a producer.
  function automatic logic producer_match(input logic                wr,
                                          input logic [REG_AW_P-1:0] rd,
                                          input logic [REG_AW_P-1:0] src);
    return wr & (rd != {REG_AW_P{1'b0}}) & (rd == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_chk.sv
// hazard_ctrl_chk: invariants of the hazard controller shadow pipeline.
//  clk, reset       clock and asynchronous active-high reset
//  e_slot, m_slot,
//  w_slot           shadow slots
//  e_rs1, e_rs2     source registers held with the E slot
// A load sitting in M must never be a forwarding source for E (load-use
// stalling guarantees this), and an empty slot always carries all-zero fields
// so a bubble can never look like a producer.
module hazard_ctrl_chk
  import pipe_ctrl_pkg::*;
(
  input logic                clk,
  input logic                reset,
  input slot_t               e_slot,
  input slot_t               m_slot,
  input slot_t               w_slot,
  input logic [REG_AW_P-1:0] e_rs1,
  input logic [REG_AW_P-1:0] e_rs2
);

  logic m_load_hit_s;
  assign m_load_hit_s = m_slot.is_load &
                        (producer_match(m_slot.valid & m_slot.reg_we, m_slot.rd, e_rs1) |
                         producer_match(m_slot.valid & m_slot.reg_we, m_slot.rd, e_rs2));

  a_no_load_fwd_from_m: assert property (@(posedge clk) disable iff (reset) !m_load_hit_s);

  a_e_empty_clean: assert property (@(posedge clk) disable iff (reset)
    e_slot.valid || ((e_slot == SLOT_EMPTY) && (e_rs1 == {REG_AW_P{1'b0}}) &&
                     (e_rs2 == {REG_AW_P{1'b0}})));

  a_m_empty_clean: assert property (@(posedge clk) disable iff (reset)
    m_slot.valid || (m_slot == SLOT_EMPTY));

  a_w_empty_clean: assert property (@(posedge clk) disable iff (reset)
    w_slot.valid || (w_slot == SLOT_EMPTY));

endmodule

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: operand forwarding select for one E-stage source register.
//  src   in  REG_AW_P  source register number held in the E shadow slot
//  m_wr  in  1         M slot is valid and writes a register
//  m_rd  in  REG_AW_P  M slot destination
//  w_wr  in  1         W slot is valid and writes a register
//  w_rd  in  REG_AW_P  W slot destination
//  sel   out FWD_W_P   FWD_SRC_M / FWD_SRC_W / FWD_SRC_RF; the younger M result wins
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW_P-1:0] src,
  input  logic                m_wr,
  input  logic [REG_AW_P-1:0] m_rd,
  input  logic                w_wr,
  input  logic [REG_AW_P-1:0] w_rd,
  output logic [FWD_W_P-1:0]  sel
);

  // Priority mux: M result is newer than W result, so it is checked first.
  always_comb begin
    sel = FWD_SRC_RF;
    if (producer_match(m_wr, m_rd, src)) begin
      sel = FWD_SRC_M;
    end else if (producer_match(w_wr, w_rd, src)) begin
      sel = FWD_SRC_W;
    end else begin
      sel = FWD_SRC_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control unit for the 5-stage core (F,D,E,M,W).
// Tracks a shadow copy of the E/M/W slots and drives stall/flush/bubble
// enables, E-stage forwarding selects and the halt drain sequence.
//  clk, reset                 clock (rising edge), asynchronous active-high reset
//  d_valid                    D slot holds a real instruction
//  d_rs1, d_rs2, d_rd         D register numbers
//  d_reg_we, d_is_load,
//  d_is_store, d_is_halt      D decode flags
//  e_redirect                 taken branch / jalr resolved in E
//  mem_ready                  data memory finished the M access
//  stall_f, stall_d           hold PC, hold F/D
//  flush_d, bubble_e          NOP into F/D, NOP into D/E
//  stall_em, bubble_w         hold D/E and E/M, NOP into M/W
//  fwd_a, fwd_b               E operand source (00 regfile, 01 M, 10 W)
//  halted                     registered, core stopped
// Controls are combinational from shadow state and inputs; priority is
// HALTED > mem stall > redirect > load-use > normal.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_P,
  parameter int FWD_W  = FWD_W_P
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_reg_we,
  input  logic              d_is_load,
  input  logic              d_is_store,
  input  logic              d_is_halt,
  input  logic              e_redirect,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              bubble_e,
  output logic              stall_em,
  output logic              bubble_w,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic              halted
);

  ctrl_state_t       state_r;
  ctrl_state_t       state_next_s;
  logic              halted_r;
  slot_t             e_slot_r;
  slot_t             m_slot_r;
  slot_t             w_slot_r;
  logic [REG_AW-1:0] e_rs1_r;
  logic [REG_AW-1:0] e_rs2_r;
  slot_t             d_slot_s;
  logic              mem_stall_s;
  logic              load_use_s;
  logic              halt_adv_s;

  // Pack D decode fields into a shadow slot; an invalid D yields an all-zero slot.
  always_comb begin
    d_slot_s = SLOT_EMPTY;
    if (d_valid) begin
      d_slot_s.valid   = 1'b1;
      d_slot_s.rd      = d_rd;
      d_slot_s.reg_we  = d_reg_we;
      d_slot_s.is_load = d_is_load;
      d_slot_s.is_mem  = d_is_load | d_is_store;
      d_slot_s.is_halt = d_is_halt;
    end else begin
      d_slot_s = SLOT_EMPTY;
    end
  end

  assign mem_stall_s = m_slot_r.valid & m_slot_r.is_mem & ~mem_ready;

  // Conservative: both source fields are compared even for I-type encodings.
  assign load_use_s = d_valid &
    (producer_match(e_slot_r.valid & e_slot_r.is_load & e_slot_r.reg_we, e_slot_r.rd, d_rs1) |
     producer_match(e_slot_r.valid & e_slot_r.is_load & e_slot_r.reg_we, e_slot_r.rd, d_rs2));

  // The halt only counts once it actually leaves D (no stall, no flush).
  assign halt_adv_s = (state_r == RUN) & ~mem_stall_s & ~e_redirect & ~load_use_s &
                      d_valid & d_is_halt;

  // State register and registered halted flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == HALTED);
    end
  end

  // Next-state logic: drain starts when a halt enters E, stops when it reaches W.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (halt_adv_s) state_next_s = DRAIN;
        else            state_next_s = RUN;
      end
      DRAIN: begin
        if (w_slot_r.valid & w_slot_r.is_halt) state_next_s = HALTED;
        else                                    state_next_s = DRAIN;
      end
      HALTED:  state_next_s = HALTED;
      default: state_next_s = RUN;
    endcase
  end

  // Output decode by state and hazard priority.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    stall_em = 1'b0;
    bubble_w = 1'b0;
    case (state_r)
      HALTED: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_em = 1'b1;
        bubble_w = 1'b1;
      end
      DRAIN: begin
        if (mem_stall_s) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_em = 1'b1;
          bubble_w = 1'b1;
        end else begin
          // Younger instructions behind the halt must not enter E either.
          stall_f  = 1'b1;
          flush_d  = 1'b1;
          bubble_e = 1'b1;
        end
      end
      RUN: begin
        if (mem_stall_s) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_em = 1'b1;
          bubble_w = 1'b1;
        end else if (e_redirect) begin
          flush_d  = 1'b1;
          bubble_e = 1'b1;
        end else if (load_use_s) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          bubble_e = 1'b1;
        end else begin
          stall_f  = 1'b0;
        end
      end
      default: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_em = 1'b1;
        bubble_w = 1'b1;
      end
    endcase
  end

  assign halted = halted_r;

  // Shadow slots advance exactly as the real pipeline registers do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_slot_r <= SLOT_EMPTY;
      m_slot_r <= SLOT_EMPTY;
      w_slot_r <= SLOT_EMPTY;
      e_rs1_r  <= {REG_AW{1'b0}};
      e_rs2_r  <= {REG_AW{1'b0}};
    end else begin
      w_slot_r <= bubble_w ? SLOT_EMPTY : m_slot_r;
      if (stall_em) begin
        e_slot_r <= e_slot_r;
        m_slot_r <= m_slot_r;
      end else begin
        m_slot_r <= e_slot_r;
        if (bubble_e || !d_valid) begin
          e_slot_r <= SLOT_EMPTY;
          e_rs1_r  <= {REG_AW{1'b0}};
          e_rs2_r  <= {REG_AW{1'b0}};
        end else begin
          e_slot_r <= d_slot_s;
          e_rs1_r  <= d_rs1;
          e_rs2_r  <= d_rs2;
        end
      end
    end
  end

  fwd_sel u_fwd_a (
    .src  (e_rs1_r),
    .m_wr (m_slot_r.valid & m_slot_r.reg_we),
    .m_rd (m_slot_r.rd),
    .w_wr (w_slot_r.valid & w_slot_r.reg_we),
    .w_rd (w_slot_r.rd),
    .sel  (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src  (e_rs2_r),
    .m_wr (m_slot_r.valid & m_slot_r.reg_we),
    .m_rd (m_slot_r.rd),
    .w_wr (w_slot_r.valid & w_slot_r.reg_we),
    .w_rd (w_slot_r.rd),
    .sel  (fwd_b)
  );

  hazard_ctrl_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .e_slot (e_slot_r),
    .m_slot (m_slot_r),
    .w_slot (w_slot_r),
    .e_rs1  (e_rs1_r),
    .e_rs2  (e_rs2_r)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each cycle the stimulus drives the D/E/M
// inputs and pushes the hand-computed output vector into a queue; a monitor
// on the falling edge pops and compares.
// Vector bit order: {stall_f, stall_d, flush_d, bubble_e, stall_em, bubble_w,
//                    fwd_a[1:0], fwd_b[1:0], halted}
module tb_hazard_ctrl;

  localparam logic [10:0] E0    = 11'b000000_00_00_0;  // nothing asserted
  localparam logic [10:0] LU    = 11'b110100_00_00_0;  // load-use stall
  localparam logic [10:0] RD    = 11'b001100_00_00_0;  // redirect flush
  localparam logic [10:0] MS    = 11'b110011_00_00_0;  // memory stall
  localparam logic [10:0] DR    = 11'b101100_00_00_0;  // halt drain
  localparam logic [10:0] HT    = 11'b110011_00_00_1;  // halted
  localparam logic [10:0] FA_W  = 11'b000000_10_00_0;  // fwd_a from W
  localparam logic [10:0] FAB_M = 11'b000000_01_01_0;  // both from M
  localparam logic [10:0] FAB_W = 11'b000000_10_10_0;  // both from W

  // flags {reg_we, is_load, is_store, is_halt}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_ALU  = 4'b1000;
  localparam logic [3:0] F_LD   = 4'b1100;
  localparam logic [3:0] F_ST   = 4'b0010;
  localparam logic [3:0] F_HT   = 4'b0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs1 = 5'd0;
  logic [4:0] d_rs2 = 5'd0;
  logic [4:0] d_rd = 5'd0;
  logic       d_reg_we = 1'b0;
  logic       d_is_load = 1'b0;
  logic       d_is_store = 1'b0;
  logic       d_is_halt = 1'b0;
  logic       e_redirect = 1'b0;
  logic       mem_ready = 1'b1;
  logic       stall_f, stall_d, flush_d, bubble_e, stall_em, bubble_w, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [10:0] act_s;

  logic [10:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs1      (d_rs1),
    .d_rs2      (d_rs2),
    .d_rd       (d_rd),
    .d_reg_we   (d_reg_we),
    .d_is_load  (d_is_load),
    .d_is_store (d_is_store),
    .d_is_halt  (d_is_halt),
    .e_redirect (e_redirect),
    .mem_ready  (mem_ready),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .bubble_e   (bubble_e),
    .stall_em   (stall_em),
    .bubble_w   (bubble_w),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .halted     (halted)
  );

  assign act_s = {stall_f, stall_d, flush_d, bubble_e, stall_em, bubble_w, fwd_a, fwd_b, halted};

  // One cycle of stimulus, driven 1 time unit after the rising edge.
  task automatic issue(input string nm, input logic rst, input logic dv,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [3:0] fl, input logic redir, input logic mrdy,
                       input logic [10:0] exp_v);
    @(posedge clk);
    #1;
    reset      = rst;
    d_valid    = dv;
    d_rs1      = rs1;
    d_rs2      = rs2;
    d_rd       = rd;
    d_reg_we   = fl[3];
    d_is_load  = fl[2];
    d_is_store = fl[1];
    d_is_halt  = fl[0];
    e_redirect = redir;
    mem_ready  = mrdy;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) issue(nm, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
  endtask

  // Reset rises mid-cycle, well away from any clock edge.
  task automatic pulse_reset(input string nm);
    issue(nm, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: compare on the falling edge whenever an expectation is pending.
  always @(negedge clk) begin
    logic [10:0] e_v;
    string       n_v;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      n_v = name_q.pop_front();
      checks++;
      if (act_s !== e_v) begin
        failures++;
        $display("FAIL %s: got %b expected %b", n_v, act_s, e_v);
      end
    end
  end

  initial begin
    // Reset state
    issue("rst_a", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    issue("rst_b", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    idle("post_rst", 2);

    // lw x5 ; add x6,x5,x1 -> one load-use stall, then fwd_a from W
    issue("lu_lw",    1'b0, 1'b1, 5'd2, 5'd0, 5'd5, F_LD,  1'b0, 1'b1, E0);
    issue("lu_stall", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, F_ALU, 1'b0, 1'b1, LU);
    issue("lu_again", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, F_ALU, 1'b0, 1'b1, E0);
    issue("lu_fwd_w", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, FA_W);
    idle("lu_idle", 3);

    // add x5 ; sub x7,x5,x5 -> both operands from M
    issue("fm_add",   1'b0, 1'b1, 5'd1, 5'd2, 5'd5, F_ALU, 1'b0, 1'b1, E0);
    issue("fm_sub",   1'b0, 1'b1, 5'd5, 5'd5, 5'd7, F_ALU, 1'b0, 1'b1, E0);
    issue("fm_fwd_m", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, FAB_M);
    idle("fm_idle", 3);

    // add x5 ; or x8 ; sub x7,x5,x5 -> both operands from W
    issue("fw_add",   1'b0, 1'b1, 5'd1, 5'd2, 5'd5, F_ALU, 1'b0, 1'b1, E0);
    issue("fw_or",    1'b0, 1'b1, 5'd1, 5'd2, 5'd8, F_ALU, 1'b0, 1'b1, E0);
    issue("fw_sub",   1'b0, 1'b1, 5'd5, 5'd5, 5'd7, F_ALU, 1'b0, 1'b1, E0);
    issue("fw_fwd_w", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, FAB_W);
    idle("fw_idle", 3);

    // redirect with lw x5 in E and its consumer in D: redirect wins
    issue("rl_lw",    1'b0, 1'b1, 5'd2, 5'd0, 5'd5, F_LD,  1'b0, 1'b1, E0);
    issue("rl_redir", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, F_ALU, 1'b1, 1'b1, RD);
    issue("rl_e_inv", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, F_ALU, 1'b0, 1'b1, E0);
    issue("rl_fwd_w", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, FA_W);
    idle("rl_idle", 3);

    // sw in M, memory busy 3 cycles, redirect held off until release
    issue("ms_sw",    1'b0, 1'b1, 5'd2, 5'd3, 5'd0, F_ST,  1'b0, 1'b1, E0);
    issue("ms_to_m",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    issue("ms_st1",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b0, MS);
    issue("ms_st2",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b1, 1'b0, MS);
    issue("ms_st3",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b1, 1'b0, MS);
    issue("ms_rel",   1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b1, 1'b1, RD);
    idle("ms_idle", 3);

    // taken branch discards a halt in D; state stays RUN
    issue("hb_beq",   1'b0, 1'b1, 5'd1, 5'd2, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    issue("hb_flush", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, F_HT,   1'b1, 1'b1, RD);
    idle("hb_run", 3);

    // add x3 ; halt -> 3 drain cycles then halted
    issue("h_add",    1'b0, 1'b1, 5'd1, 5'd2, 5'd3, F_ALU, 1'b0, 1'b1, E0);
    issue("h_halt",   1'b0, 1'b1, 5'd0, 5'd0, 5'd0, F_HT,  1'b0, 1'b1, E0);
    issue("h_drain1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, DR);
    issue("h_drain2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, DR);
    issue("h_drain3", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, DR);
    issue("h_halted1", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, HT);
    issue("h_halted2", 1'b0, 1'b1, 5'd1, 5'd2, 5'd9, F_ALU, 1'b1, 1'b1, HT);
    issue("h_reset",  1'b1, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, E0);
    idle("h_run", 2);

    // asynchronous reset in the middle of a drain
    issue("ar_halt",  1'b0, 1'b1, 5'd0, 5'd0, 5'd0, F_HT,  1'b0, 1'b1, E0);
    issue("ar_drain", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, F_NONE, 1'b0, 1'b1, DR);
    pulse_reset("ar_pulse");
    idle("ar_run", 3);

    // let the monitor consume the last expectation, bounded
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
